// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
//
// Time-multiplexed driver for an N-digit common-anode 7-segment display.
// A refresh counter holds each digit selected for REFRESH_DIV clocks, and the
// digit index walks 0..NUM_DIGITS-1 and wraps. New digit codes are
// double-buffered: a load lands in a shadow register and is copied into the
// display register only when the scan wraps back to digit 0, so a frame never
// shows a mix of old and new digits.
//
// Parameters
//   NUM_DIGITS  : digits scanned (>= 1)
//   REFRESH_DIV : clocks each digit stays selected (>= 1)
//   HEX_MODE    : 1 = codes 10..15 show A,b,C,d,E,F; 0 = they show a dash
//
// Ports
//   clk          : system clock
//   reset        : synchronous, active-high reset
//   value        : packed 4-bit digit codes, digit i = value[4i+3:4i]
//   dp           : per-digit decimal point enables (1 = lit)
//   load         : strobe, captures value/dp into the shadow register
//   blank        : live, 1 turns the whole display off
//   lz_suppress  : live, 1 hides leading zeros (digit 0 always shown)
//   leds         : active-low segments, [0]=a .. [6]=g, [7]=dp
//   digit_sel    : active-low one-hot anode select
//   frame_done   : one-cycle pulse as the scan wraps to digit 0
// -----------------------------------------------------------------------------
module seg_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int HEX_MODE    = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    load,
    input  logic                    blank,
    input  logic                    lz_suppress,
    output logic [7:0]              leds,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_done
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] SEL_OFF  = {NUM_DIGITS{1'b1}};
    localparam logic [6:0]            SEG_DASH = 7'b0111111;
    localparam logic [6:0]            SEG_OFF  = 7'b1111111;
    localparam logic                  HEX_EN   = (HEX_MODE != 0);

    // Active-low g..a pattern for one 4-bit code. Codes above 9 show letters
    // only when hex decoding is enabled, otherwise a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] code, input logic hex_en);
        logic [6:0] seg;
        case (code)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            4'd10:   seg = 7'b0001000;
            4'd11:   seg = 7'b0000011;
            4'd12:   seg = 7'b1000110;
            4'd13:   seg = 7'b0100001;
            4'd14:   seg = 7'b0000110;
            4'd15:   seg = 7'b0001110;
            default: seg = SEG_DASH;
        endcase
        return (hex_en || (code <= 4'd9)) ? seg : SEG_DASH;
    endfunction

    // Scan state
    logic [CNT_W-1:0]        cnt_r;
    logic [IDX_W-1:0]        idx_r;
    logic [CNT_W-1:0]        cnt_next_s;
    logic [IDX_W-1:0]        idx_next_s;
    logic                    cnt_tc_s;
    logic                    wrap_s;

    // Double buffer
    logic [4*NUM_DIGITS-1:0] shadow_val_r;
    logic [NUM_DIGITS-1:0]   shadow_dp_r;
    logic [4*NUM_DIGITS-1:0] disp_val_r;
    logic [NUM_DIGITS-1:0]   disp_dp_r;
    logic                    pending_r;

    // Current-digit view of the display register
    logic [NUM_DIGITS-1:0]   zero_above_s;
    logic [3:0]              cur_code_s;
    logic                    cur_dp_s;
    logic                    cur_zero_above_s;
    logic [NUM_DIGITS-1:0]   sel_s;
    logic                    suppress_s;
    logic [6:0]              seg_s;

    // Output registers
    logic [7:0]              leds_r;
    logic [NUM_DIGITS-1:0]   digit_sel_r;
    logic                    frame_done_r;

    assign cnt_tc_s = (cnt_r == CNT_LAST);
    assign wrap_s   = cnt_tc_s && (idx_r == IDX_LAST);

    // Next refresh count and digit index; the index only moves at terminal count.
    always_comb begin
        cnt_next_s = cnt_r;
        idx_next_s = idx_r;
        if (cnt_tc_s) begin
            cnt_next_s = {CNT_W{1'b0}};
            if (idx_r == IDX_LAST) begin
                idx_next_s = {IDX_W{1'b0}};
            end else begin
                idx_next_s = idx_r + IDX_W'(1);
            end
        end else begin
            cnt_next_s = cnt_r + CNT_W'(1);
        end
    end

    // Refresh counter and digit index registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
            idx_r <= {IDX_W{1'b0}};
        end else begin
            cnt_r <= cnt_next_s;
            idx_r <= idx_next_s;
        end
    end

    // Shadow/display buffering. The wrap copy uses the pre-edge shadow, so a
    // load on the wrap edge is kept pending and shows from the next frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_val_r <= {(4*NUM_DIGITS){1'b0}};
            shadow_dp_r  <= {NUM_DIGITS{1'b0}};
            disp_val_r   <= {(4*NUM_DIGITS){1'b0}};
            disp_dp_r    <= {NUM_DIGITS{1'b0}};
            pending_r    <= 1'b0;
        end else begin
            if (wrap_s && pending_r) begin
                disp_val_r <= shadow_val_r;
                disp_dp_r  <= shadow_dp_r;
            end else begin
                disp_val_r <= disp_val_r;
                disp_dp_r  <= disp_dp_r;
            end
            if (load) begin
                shadow_val_r <= value;
                shadow_dp_r  <= dp;
                pending_r    <= 1'b1;
            end else if (wrap_s) begin
                pending_r    <= 1'b0;
            end else begin
                pending_r    <= pending_r;
            end
        end
    end

    // zero_above_s[i] is set when digit i and every more-significant digit are
    // zero; built from the top digit down with a running AND.
    always_comb begin : zero_scan
        logic zero_run;
        zero_run     = 1'b1;
        zero_above_s = {NUM_DIGITS{1'b0}};
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run        = zero_run && (disp_val_r[4*i +: 4] == 4'd0);
            zero_above_s[i] = zero_run;
        end
    end

    // Pick out the code, point and suppression flag for the selected digit
    // and form the active-low anode pattern.
    always_comb begin
        cur_code_s       = 4'd0;
        cur_dp_s         = 1'b0;
        cur_zero_above_s = 1'b0;
        sel_s            = SEL_OFF;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_r == IDX_W'(i)) begin
                cur_code_s       = disp_val_r[4*i +: 4];
                cur_dp_s         = disp_dp_r[i];
                cur_zero_above_s = zero_above_s[i];
                sel_s[i]         = 1'b0;
            end else begin
                sel_s[i]         = 1'b1;
            end
        end
    end

    assign suppress_s = lz_suppress && (idx_r != {IDX_W{1'b0}}) && cur_zero_above_s;

    // Segment pattern for the selected digit; a suppressed digit keeps its point.
    always_comb begin
        seg_s = SEG_OFF;
        if (suppress_s) begin
            seg_s = SEG_OFF;
        end else begin
            seg_s = seg_decode(cur_code_s, HEX_EN);
        end
    end

    // Registered pin drivers; they trail the digit index by one clock.
    always_ff @(posedge clk) begin
        if (reset) begin
            leds_r       <= 8'hFF;
            digit_sel_r  <= SEL_OFF;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= wrap_s;
            if (blank) begin
                leds_r      <= 8'hFF;
                digit_sel_r <= SEL_OFF;
            end else begin
                leds_r      <= {~cur_dp_s, seg_s};
                digit_sel_r <= sel_s;
            end
        end
    end

    assign leds       = leds_r;
    assign digit_sel  = digit_sel_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// Bench for seg_scan_driver. Four instances share the stimulus:
//   u_hex   : 4 digits, 3 clocks per digit, hex letters
//   u_dec   : 4 digits, 3 clocks per digit, dashes for 10..15
//   u_one   : 1 digit,  2 clocks per digit
//   u_three : 3 digits, 1 clock per digit
// A reference model predicts every output from elapsed time since reset and
// the frame-buffer rules; a vector table and a few sequences add fixed
// expected patterns.
// -----------------------------------------------------------------------------
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        reset, load, blank, lz;
    logic [15:0] value;
    logic [3:0]  dp;

    logic [7:0]  leds0, leds1, leds2, leds3;
    logic [3:0]  sel0, sel1;
    logic [0:0]  sel2;
    logic [2:0]  sel3;
    logic        fd0, fd1, fd2, fd3;

    always #5 clk = ~clk;

    seg_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(3), .HEX_MODE(1)) u_hex (
        .clk(clk), .reset(reset), .value(value), .dp(dp), .load(load),
        .blank(blank), .lz_suppress(lz), .leds(leds0), .digit_sel(sel0), .frame_done(fd0));
    seg_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(3), .HEX_MODE(0)) u_dec (
        .clk(clk), .reset(reset), .value(value), .dp(dp), .load(load),
        .blank(blank), .lz_suppress(lz), .leds(leds1), .digit_sel(sel1), .frame_done(fd1));
    seg_scan_driver #(.NUM_DIGITS(1), .REFRESH_DIV(2), .HEX_MODE(1)) u_one (
        .clk(clk), .reset(reset), .value(value[3:0]), .dp(dp[0:0]), .load(load),
        .blank(blank), .lz_suppress(lz), .leds(leds2), .digit_sel(sel2), .frame_done(fd2));
    seg_scan_driver #(.NUM_DIGITS(3), .REFRESH_DIV(1), .HEX_MODE(0)) u_three (
        .clk(clk), .reset(reset), .value(value[11:0]), .dp(dp[2:0]), .load(load),
        .blank(blank), .lz_suppress(lz), .leds(leds3), .digit_sel(sel3), .frame_done(fd3));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int         n_a   [4] = '{4, 4, 1, 3};
    int         div_a [4] = '{3, 3, 2, 1};
    bit         hex_a [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [6:0] seg_tbl [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    int          t_m = 0;
    logic [15:0] sh_v [4];
    logic [15:0] dv_v [4];
    logic [3:0]  sh_d [4];
    logic [3:0]  dv_d [4];
    bit          pend [4];
    logic [7:0]  e_leds [4];
    logic [3:0]  e_sel  [4];
    logic        e_fd   [4];

    function automatic logic [3:0] digit_of(input logic [15:0] v, input int i);
        return 4'(v >> (4 * i));
    endfunction

    function automatic logic [7:0] ref_leds(input int k, input int idx, input logic bl, input logic lzs);
        logic [3:0] code;
        logic [6:0] seg;
        bit         supp;
        if (bl) return 8'hFF;
        code = digit_of(dv_v[k], idx);
        supp = 1'b0;
        if (lzs && idx > 0) begin
            supp = 1'b1;
            for (int j = idx; j < n_a[k]; j++)
                if (digit_of(dv_v[k], j) != 4'd0) supp = 1'b0;
        end
        if (supp)                          seg = 7'h7F;
        else if (code > 4'd9 && !hex_a[k]) seg = 7'b0111111;
        else                               seg = seg_tbl[code];
        return {~dv_d[k][idx], seg};
    endfunction

    // Predict what each instance shows after the coming clock edge and
    // advance the model across that edge.
    task automatic model_edge();
        for (int k = 0; k < 4; k++) begin
            logic [3:0]  msk;
            logic [15:0] vm;
            int          idx;
            msk = 4'((32'd1 << n_a[k]) - 32'd1);
            vm  = 16'((32'd1 << (4 * n_a[k])) - 32'd1);
            if (reset) begin
                e_leds[k] = 8'hFF; e_sel[k] = msk; e_fd[k] = 1'b0;
                sh_v[k] = '0; dv_v[k] = '0; sh_d[k] = '0; dv_d[k] = '0; pend[k] = 1'b0;
            end else begin
                idx       = (t_m / div_a[k]) % n_a[k];
                e_leds[k] = ref_leds(k, idx, blank, lz);
                e_sel[k]  = blank ? msk : (msk & ~(4'b0001 << idx));
                e_fd[k]   = ((t_m + 1) % (div_a[k] * n_a[k])) == 0;
                if (e_fd[k] && pend[k]) begin
                    dv_v[k] = sh_v[k]; dv_d[k] = sh_d[k]; pend[k] = 1'b0;
                end
                if (load) begin
                    sh_v[k] = value & vm; sh_d[k] = dp & msk; pend[k] = 1'b1;
                end
            end
        end
        t_m = reset ? 0 : t_m + 1;
    endtask

    task automatic step();
        logic [7:0] al [4];
        logic [3:0] as [4];
        logic       af [4];
        model_edge();
        @(posedge clk);
        #1;
        al = '{leds0, leds1, leds2, leds3};
        as = '{sel0, sel1, {3'b000, sel2}, {1'b0, sel3}};
        af = '{fd0, fd1, fd2, fd3};
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("leds u%0d t=%0d", k, t_m), 32'(al[k]), 32'(e_leds[k]));
            chk($sformatf("digit_sel u%0d t=%0d", k, t_m), 32'(as[k]), 32'(e_sel[k]));
            chk($sformatf("frame_done u%0d t=%0d", k, t_m), 32'(af[k]), 32'(e_fd[k]));
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_fd();
        int w;
        w = 0;
        step();
        while (fd0 !== 1'b1 && w < 40) begin
            step();
            w++;
        end
        chk("wait frame_done", 32'(fd0), 32'd1);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        value = v; dp = d; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic [15:0] v;
        logic [3:0]  d;
        logic        lzs;
        logic [31:0] ex_hex;   // digit3..digit0, one byte each
        logic [31:0] ex_dec;
    } vec_t;

    vec_t vecs [7];

    initial begin
        logic [7:0] cap_h [4];
        logic [7:0] cap_d [4];
        int         p1, p2, w;

        vecs[0] = '{16'h1234, 4'h0, 1'b0, 32'hF9A4B099, 32'hF9A4B099};
        vecs[1] = '{16'hFA09, 4'h0, 1'b0, 32'h8E88C090, 32'hBFBFC090};
        vecs[2] = '{16'h0050, 4'h4, 1'b1, 32'hFF7F92C0, 32'hFF7F92C0};
        vecs[3] = '{16'h0000, 4'h0, 1'b1, 32'hFFFFFFC0, 32'hFFFFFFC0};
        vecs[4] = '{16'h0050, 4'h4, 1'b0, 32'hC04092C0, 32'hC04092C0};
        vecs[5] = '{16'hBCDE, 4'hA, 1'b1, 32'h03C62186, 32'h3FBF3FBF};
        vecs[6] = '{16'h6789, 4'h1, 1'b0, 32'h82F88010, 32'h82F88010};

        reset = 1'b1; load = 1'b0; blank = 1'b0; lz = 1'b0; value = 16'h0; dp = 4'h0;
        #1;
        steps(3);
        reset = 1'b0;

        // Table: load, let two frames pass, capture one full frame per digit.
        for (int r = 0; r < 7; r++) begin
            lz = vecs[r].lzs; blank = 1'b0;
            do_load(vecs[r].v, vecs[r].d);
            for (int k = 0; k < 4; k++) begin cap_h[k] = 8'hxx; cap_d[k] = 8'hxx; end
            for (int c = 0; c < 30; c++) begin
                step();
                if (c >= 18) begin
                    for (int k = 0; k < 4; k++) begin
                        logic [3:0] s;
                        s = ~(4'b0001 << k);
                        if (sel0 == s) cap_h[k] = leds0;
                        if (sel1 == s) cap_d[k] = leds1;
                    end
                end
            end
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("vec%0d hex digit%0d", r, k), 32'(cap_h[k]), 32'(vecs[r].ex_hex[8*k +: 8]));
                chk($sformatf("vec%0d dec digit%0d", r, k), 32'(cap_d[k]), 32'(vecs[r].ex_dec[8*k +: 8]));
            end
        end
        lz = 1'b0;

        // Tear-free load: 5678 loaded at index 1 must not reach this frame.
        do_load(16'h1234, 4'h0);
        steps(24);
        wait_fd();
        steps(3);
        do_load(16'h5678, 4'h0);
        w = 0;
        while (sel0 !== 4'b0111 && w < 20) begin step(); w++; end
        chk("tearfree old digit3 sel", 32'(sel0), 32'h7);
        chk("tearfree old digit3 leds", 32'(leds0), 32'hF9);
        wait_fd();
        step();
        chk("tearfree new digit0 sel", 32'(sel0), 32'hE);
        chk("tearfree new digit0 leds", 32'(leds0), 32'h80);

        // Two loads in one frame: only the last is shown.
        steps(2);
        do_load(16'h1111, 4'h0);
        steps(2);
        do_load(16'h2222, 4'h0);
        wait_fd();
        step();
        chk("lastload digit0 leds", 32'(leds0), 32'hA4);

        // Load on the wrap edge: pending 3333 is shown, 9999 waits a frame.
        wait_fd();
        steps(2);
        do_load(16'h3333, 4'h0);
        w = 0;
        while (((t_m + 1) % 12) != 0 && w < 12) begin step(); w++; end
        do_load(16'h9999, 4'h0);
        chk("wrapload frame_done", 32'(fd0), 32'd1);
        step();
        chk("wrapload old digit0 sel", 32'(sel0), 32'hE);
        chk("wrapload old digit0 leds", 32'(leds0), 32'hB0);
        wait_fd();
        step();
        chk("wrapload new digit0 leds", 32'(leds0), 32'h90);

        // Blanking mid-scan for 20 cycles.
        wait_fd();
        steps(4);
        blank = 1'b1;
        step();
        chk("blank leds", 32'(leds0), 32'hFF);
        chk("blank sel", 32'(sel0), 32'hF);
        p1 = -1; p2 = -1;
        for (int c = 1; c < 20; c++) begin
            step();
            if (fd0 === 1'b1) begin
                if (p1 < 0) p1 = c; else p2 = c;
            end
        end
        chk("blank frame period", 32'(p2 - p1), 32'd12);
        blank = 1'b0;
        step();
        chk("unblank resume sel", 32'(sel0), 32'hE);
        chk("unblank resume leds", 32'(leds0), 32'h90);

        // Reset mid-scan.
        steps(5);
        reset = 1'b1;
        step();
        chk("midreset leds", 32'(leds0), 32'hFF);
        chk("midreset sel", 32'(sel0), 32'hF);
        chk("midreset frame_done", 32'(fd0), 32'd0);
        reset = 1'b0;
        step();
        chk("postreset sel", 32'(sel0), 32'hE);
        chk("postreset leds", 32'(leds0), 32'hC0);

        // Randomised traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            load  = ($urandom_range(0, 7) == 0);
            value = 16'($urandom);
            if ($urandom_range(0, 2) == 0) value = value & 16'h00FF;
            if ($urandom_range(0, 3) == 0) value = value & 16'h000F;
            dp    = 4'($urandom);
            lz    = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 29) == 0) blank = ~blank;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
